// File: rtl/adder_arbiter.sv
// Two-requester front end for a single shared five-bit adder.
// Round-robin grant, operands latched at grant, result returned two cycles later.

module five_bit_adder (
   input  logic [4:0] x,
   input  logic [4:0] y,
   input  logic       cin,
   output logic [4:0] sum,
   output logic       cout
);

   assign {cout, sum} = {1'b0, x} + {1'b0, y} + {5'b0, cin};

endmodule

module adder_arbiter #(
   parameter int WIDTH = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_a,
   input  logic             req_b,
   input  logic [WIDTH-1:0] x_a,
   input  logic [WIDTH-1:0] y_a,
   input  logic [WIDTH-1:0] x_b,
   input  logic [WIDTH-1:0] y_b,
   output logic             ack_a,
   output logic             ack_b,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             res_valid,
   output logic             res_id,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic             grant;
   logic             grant_id;
   logic             win_id;
   logic             last_served;
   logic [WIDTH-1:0] x_lat;
   logic [WIDTH-1:0] y_lat;
   logic [WIDTH-1:0] add_sum;
   logic             add_carry;

   five_bit_adder u_adder (
      .x    (x_lat),
      .y    (y_lat),
      .cin  (1'b0),
      .sum  (add_sum),
      .cout (add_carry)
   );

   // On a tie the requester that was not granted last time wins.
   always_comb begin
      state_next = state;
      grant      = 1'b0;
      grant_id   = 1'b0;
      unique case (state)
         IDLE: begin
            if (req_a || req_b) begin
               grant      = 1'b1;
               grant_id   = (req_a && req_b) ? ~last_served : req_b;
               state_next = ADD;
            end
         end
         ADD:     state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy      = (state != IDLE);
      res_valid = (state == RESP);
      ack_a     = res_valid & ~win_id;
      ack_b     = res_valid & win_id;
   end

   // last_served resets to B so that A takes the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         last_served <= 1'b1;
         win_id      <= 1'b0;
         x_lat       <= '0;
         y_lat       <= '0;
         sum         <= '0;
         carry       <= 1'b0;
         res_id      <= 1'b0;
      end else begin
         state <= state_next;
         if (grant) begin
            win_id      <= grant_id;
            last_served <= grant_id;
            x_lat       <= grant_id ? x_b : x_a;
            y_lat       <= grant_id ? y_b : y_a;
         end
         if (state == ADD) begin
            sum    <= add_sum;
            carry  <= add_carry;
            res_id <= win_id;
         end
      end
   end

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed self-checking bench for adder_arbiter: single requests, overflow,
// late operand changes, mid-operation reset and continuous contention.

module tb_adder_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_a = 1'b0;
   logic       req_b = 1'b0;
   logic [4:0] x_a = '0;
   logic [4:0] y_a = '0;
   logic [4:0] x_b = '0;
   logic [4:0] y_b = '0;
   logic       ack_a;
   logic       ack_b;
   logic [4:0] sum;
   logic       carry;
   logic       res_valid;
   logic       res_id;
   logic       busy;

   int check_count = 0;
   int error_count = 0;

   always #5 clk = ~clk;

   adder_arbiter #(.WIDTH(5)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_a     (req_a),
      .req_b     (req_b),
      .x_a       (x_a),
      .y_a       (y_a),
      .x_b       (x_b),
      .y_b       (y_b),
      .ack_a     (ack_a),
      .ack_b     (ack_b),
      .sum       (sum),
      .carry     (carry),
      .res_valid (res_valid),
      .res_id    (res_id),
      .busy      (busy)
   );

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      check_count++;
      if (observed !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic ra, input logic rb,
                                input logic [4:0] xa, input logic [4:0] ya,
                                input logic [4:0] xb, input logic [4:0] yb);
      req_a = ra;
      req_b = rb;
      x_a   = xa;
      y_a   = ya;
      x_b   = xb;
      y_b   = yb;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Starts in an IDLE cycle, ends in the following IDLE cycle (3 cycles later).
   // Operands are scrambled during ADD; reqs are dropped there unless hold is set.
   task automatic runTransaction(input string tag, input logic ra, input logic rb,
                                 input logic [4:0] xa, input logic [4:0] ya,
                                 input logic [4:0] xb, input logic [4:0] yb,
                                 input logic hold, input logic exp_id,
                                 input logic [4:0] exp_sum, input logic exp_carry);
      applyStimulus(ra, rb, xa, ya, xb, yb);
      checkOutput({tag, " idle busy"}, busy, 0);
      checkOutput({tag, " idle res_valid"}, res_valid, 0);
      nextCycle();
      checkOutput({tag, " add busy"}, busy, 1);
      checkOutput({tag, " add res_valid"}, res_valid, 0);
      checkOutput({tag, " add ack_a"}, ack_a, 0);
      checkOutput({tag, " add ack_b"}, ack_b, 0);
      applyStimulus(hold ? ra : 1'b0, hold ? rb : 1'b0,
                    xa ^ 5'd23, ya ^ 5'd23, xb ^ 5'd23, yb ^ 5'd23);
      nextCycle();
      checkOutput({tag, " resp res_valid"}, res_valid, 1);
      checkOutput({tag, " resp ack_a"}, ack_a, !exp_id);
      checkOutput({tag, " resp ack_b"}, ack_b, exp_id);
      checkOutput({tag, " resp res_id"}, res_id, exp_id);
      checkOutput({tag, " resp sum"}, sum, exp_sum);
      checkOutput({tag, " resp carry"}, carry, exp_carry);
      checkOutput({tag, " resp busy"}, busy, 1);
      applyStimulus(hold ? ra : 1'b0, hold ? rb : 1'b0, xa, ya, xb, yb);
      nextCycle();
      checkOutput({tag, " after res_valid"}, res_valid, 0);
      checkOutput({tag, " after ack_a"}, ack_a, 0);
      checkOutput({tag, " after ack_b"}, ack_b, 0);
      checkOutput({tag, " after sum hold"}, sum, exp_sum);
      checkOutput({tag, " after carry hold"}, carry, exp_carry);
      checkOutput({tag, " after res_id hold"}, res_id, exp_id);
      checkOutput({tag, " after busy"}, busy, 0);
   endtask

   always @(negedge clk) begin
      checkOutput("ack exclusive", {7'b0, ack_a & ack_b}, 8'd0);
      checkOutput("valid vs ack", {7'b0, res_valid}, {7'b0, ack_a | ack_b});
   end

   initial begin
      $display("[TB] starting adder_arbiter bench");
      nextCycle();
      nextCycle();
      checkOutput("reset sum", sum, 0);
      checkOutput("reset carry", carry, 0);
      checkOutput("reset res_valid", res_valid, 0);
      checkOutput("reset res_id", res_id, 0);
      checkOutput("reset ack_a", ack_a, 0);
      checkOutput("reset ack_b", ack_b, 0);
      checkOutput("reset busy", busy, 0);
      rst_n = 1'b1;

      runTransaction("single a",   1, 0,  7,  9,  0, 0, 0, 0, 5'd16, 0);
      runTransaction("overflow b", 0, 1,  0,  0, 31, 1, 0, 1, 5'd0,  1);
      runTransaction("late x_a",   1, 0,  3,  4,  0, 0, 0, 0, 5'd7,  0);
      runTransaction("tie to b",   1, 1,  1,  2,  6, 7, 0, 1, 5'd13, 0);

      // Reset during ADD of an A request: A was granted last, yet A must win the next tie.
      applyStimulus(1, 0, 5, 5, 0, 0);
      nextCycle();
      checkOutput("midop busy before reset", busy, 1);
      applyStimulus(0, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      #1;
      checkOutput("midop sum", sum, 0);
      checkOutput("midop carry", carry, 0);
      checkOutput("midop res_id", res_id, 0);
      checkOutput("midop res_valid", res_valid, 0);
      checkOutput("midop ack_a", ack_a, 0);
      checkOutput("midop ack_b", ack_b, 0);
      checkOutput("midop busy", busy, 0);
      nextCycle();
      nextCycle();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         nextCycle();
         checkOutput("post reset no res_valid", res_valid, 0);
         checkOutput("post reset no ack_a", ack_a, 0);
         checkOutput("post reset busy", busy, 0);
      end

      runTransaction("contend 1 a", 1, 1, 10, 5, 20, 20, 1, 0, 5'd15, 0);
      runTransaction("contend 2 b", 1, 1, 10, 5, 20, 20, 1, 1, 5'd8,  1);
      runTransaction("contend 3 a", 1, 1, 10, 5, 20, 20, 1, 0, 5'd15, 0);
      runTransaction("contend 4 b", 1, 1, 10, 5, 20, 20, 1, 1, 5'd8,  1);
      applyStimulus(0, 0, 0, 0, 0, 0);
      nextCycle();
      checkOutput("final idle busy", busy, 0);
      checkOutput("final sum hold", sum, 8);

      $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
      $finish;
   end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 5, operand width; only 5 is supported, matching the shared five_bit_adder datapath.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous reset, active-low.
REQ-004 SHALL have ports req_a, req_b  input  1 each  add request from requester A or B.
REQ-005 SHALL have ports x_a, y_a, x_b, y_b  input  5 each  operands of each requester.
REQ-006 SHALL have ports ack_a, ack_b  output  1 each  one-cycle completion pulse to the served requester.
REQ-007 SHALL have port sum  output  5  registered sum of the served request.
REQ-008 SHALL have port carry  output  1  registered carry-out of the served request.
REQ-009 SHALL have port res_valid  output  1  sum, carry and res_id valid this cycle.
REQ-010 SHALL have port res_id  output  1  served requester: 0 = A, 1 = B.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-012 SHALL contain exactly one five_bit_adder instance, with carry-in 0, shared by both requesters.
REQ-013 SHALL implement the FSM IDLE -> ADD -> RESP -> IDLE; IDLE holds while req_a = req_b = 0.
REQ-014 In IDLE with any request, SHALL pick a winner, latch its 5-bit operands and id into internal registers, and go to ADD next cycle.
REQ-015 Arbitration SHALL be round-robin: if only one request, it wins; if both, the requester not served last wins.
REQ-016 last_served SHALL update only on the grant decision, not on ack.
REQ-017 In ADD, SHALL drive the adder from the latched operands and register its sum and carry; SHALL go to RESP.
REQ-018 In RESP, SHALL assert res_valid = 1, res_id = winner, and the winner's ack for exactly one cycle; SHALL return to IDLE.
REQ-019 Latency SHALL be fixed: request seen in IDLE at cycle N -> res_valid and ack at cycle N+2.
REQ-020 Back-to-back service: the IDLE cycle after RESP SHALL accept a new request, giving one result every 3 cycles.
REQ-021 Requests and operand changes during ADD or RESP SHALL be ignored; latched operands are final.
REQ-022 If a requester drops req after the grant, the transaction SHALL still complete with ack.
REQ-023 A requester holding req through its ack SHALL be re-requesting; under continuous contention, grants SHALL alternate A, B, A, B.
REQ-024 Arithmetic SHALL be unsigned modulo 32 with carry = bit 5 of x + y; no saturation.
REQ-025 sum, carry and res_id SHALL hold their last values while res_valid = 0.
REQ-026 ack_a and ack_b SHALL never be high in the same cycle.

Reset
REQ-027 While rst_n = 0, regardless of clk: state = IDLE; sum = 0; carry = 0; res_valid = 0; res_id = 0; ack_a = 0; ack_b = 0; busy = 0; last_served = B, so A wins the first tie.
REQ-028 Reset asserted during ADD or RESP SHALL abort the transaction with no ack or res_valid pulse.
REQ-029 After rst_n rises, the first request SHALL be sampled on the next rising edge.

Verification
REQ-030 Single request: req_a = 1, x_a = 5'd7, y_a = 5'd9 at cycle N -> cycle N+2: sum = 16, carry = 0, res_id = 0, ack_a pulse, res_valid pulse.
REQ-031 Overflow: req_b = 1, x_b = 5'd31, y_b = 5'd1 -> sum = 0, carry = 1, res_id = 1, ack_b only.
REQ-032 Tie after reset, both held high with distinct operands -> results ordered A, B, A, B, spaced 3 cycles; A's first result at cycle N+2.
REQ-033 Operand change after grant: x_a changes from 3 to 20 during ADD -> result uses 3.
REQ-034 Reset mid-op: rst_n low during ADD -> all outputs 0 immediately; no ack after release; next tie goes to A.
REQ-035 Every cycle, check: ack_a & ack_b = 0; res_valid = ack_a | ack_b; busy = 0 only in IDLE.
